// File: rtl/if_id_stage_pkg.sv
// Shared IF/ID definitions: default widths, NOP encoding and skid-buffer FSM states.
// Pure declarations; no timing or handshake behaviour lives here.
package if_id_stage_pkg;

   localparam int PC_W_DEF    = 10;
   localparam int INSTR_W_DEF = 32;
   localparam int CNT_W_DEF   = 16;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } ifid_state_t;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-to-decode handshake bundle. The slave modport is the IF/ID stage;
// the master modport is whatever drives fetch data and decode ready/flush.
interface if_id_stage_if
   import if_id_stage_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) ();

   logic               if_valid;
   logic [PC_W-1:0]    if_pc;
   logic [INSTR_W-1:0] if_instr;
   logic               if_ready;
   logic               id_valid;
   logic               id_ready;
   logic [PC_W-1:0]    id_pc;
   logic [PC_W-1:0]    id_pc_plus1;
   logic [INSTR_W-1:0] id_instr;
   logic               flush;

   modport slave (
      input  if_valid, if_pc, if_instr, id_ready, flush,
      output if_ready, id_valid, id_pc, id_pc_plus1, id_instr
   );

   modport master (
      output if_valid, if_pc, if_instr, id_ready, flush,
      input  if_ready, id_valid, id_pc, id_pc_plus1, id_instr
   );

endinterface

// File: rtl/if_id_stage_pipe_entry_reg.sv
// Load-enabled {pc, instr} holding register; one cycle from load to output.
// No handshake of its own: the owner decides when to load.
module pipe_entry_reg
   import if_id_stage_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               load,
   input  logic [PC_W-1:0]    pc_d,
   input  logic [INSTR_W-1:0] instr_d,
   output logic [PC_W-1:0]    pc_q,
   output logic [INSTR_W-1:0] instr_q
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= '0;
         instr_q <= '0;
      end else if (load) begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID boundary with a 2-entry skid buffer: accepted beat shows on id_* one cycle later, in order.
// if_ready is a flop (drops only when both entries are full); flush empties everything. Option: IFID_STALL_CNT_EN.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
`ifdef IFID_STALL_CNT_EN
   ,
   parameter int CNT_W   = CNT_W_DEF
`endif
) (
   input  logic              clock,
   input  logic              reset_n,
   if_id_stage_if.slave      bus
`ifdef IFID_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_count
`endif
);

   ifid_state_t        state_q, state_d;
   logic               if_ready_q, id_valid_q;
   logic               accept, deliver;
   logic               main_ld, skid_ld, main_from_skid;
   logic [PC_W-1:0]    main_pc, skid_pc, main_pc_d;
   logic [INSTR_W-1:0] main_instr, skid_instr, main_instr_d;

   assign accept  = bus.if_valid & if_ready_q;
   assign deliver = id_valid_q & bus.id_ready;

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_ld = 1'b1;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && !deliver) begin
                  skid_ld = 1'b1;
                  state_d = ST_TWO;
               end else if (accept && deliver) begin
                  main_ld = 1'b1;
               end else if (deliver) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // if_ready is low here, so only the skid-to-main move can happen
               if (deliver) begin
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign main_pc_d    = main_from_skid ? skid_pc    : bus.if_pc;
   assign main_instr_d = main_from_skid ? skid_instr : bus.if_instr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_EMPTY;
         if_ready_q <= 1'b1;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         if_ready_q <= (state_d != ST_TWO);
         id_valid_q <= (state_d != ST_EMPTY);
      end
   end

   pipe_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (main_ld),
      .pc_d    (main_pc_d),
      .instr_d (main_instr_d),
      .pc_q    (main_pc),
      .instr_q (main_instr)
   );

   pipe_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (skid_ld),
      .pc_d    (bus.if_pc),
      .instr_d (bus.if_instr),
      .pc_q    (skid_pc),
      .instr_q (skid_instr)
   );

   assign bus.if_ready    = if_ready_q;
   assign bus.id_valid    = id_valid_q;
   assign bus.id_pc       = main_pc;
   assign bus.id_pc_plus1 = main_pc + PC_W'(1);
   assign bus.id_instr    = id_valid_q ? main_instr : INSTR_W'(NOP_INSTR);

`ifdef IFID_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;

   // Saturating; only reset clears it, flush merely masks the increment
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else if (id_valid_q && !bus.id_ready && !bus.flush && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule
